// File: rtl/seg7_scan_decoder.sv
// rtl/seg7_scan_decoder.sv - rebuilds the 32-bit word shown on a scanned 8-digit 7-segment display
//
// Samples the multiplexed anode/segment pins, waits for each digit activation
// to settle, decodes the segment pattern back to a nibble and publishes a word
// once all eight digits have been captured.
//
// Ports
//   clk          system clock
//   rst          synchronous, active-high reset
//   anodes       digit select, active-low, bit i = digit i
//   cnodes       segments, active-low, [0]=a..[6]=g, [7]=dp
//   word         last complete frame, digit i -> word[4i+3:4i]
//   word_valid   one-cycle pulse when word updates
//   word_changed one-cycle pulse with word_valid when the new word differs
//   dp_mask      decimal points of the frame in word (1 = lit)
//   seg_err      frame in word held at least one undecodable pattern
//   stale        no digit captured for TIMEOUT_CYCLES cycles
//   frame_count  completed frames since reset, wrapping
module seg7_scan_decoder #(
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1048576,
  parameter int FRAME_CNT_W    = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             anodes,
  input  logic [7:0]             cnodes,
  output logic [31:0]            word,
  output logic                   word_valid,
  output logic                   word_changed,
  output logic [7:0]             dp_mask,
  output logic                   seg_err,
  output logic                   stale,
  output logic [FRAME_CNT_W-1:0] frame_count
);

  localparam int SC_W = $clog2(STABLE_CYCLES + 1);
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {ST_WAIT, ST_SETTLE, ST_HOLD} state_t;

  state_t            state;
  logic [SC_W-1:0]   stab_cnt;
  logic [TO_W-1:0]   tmo_cnt;
  logic [7:0]        s_an, s_cn;
  logic [7:0]        p_an, p_cn;
  logic [7:0]        seen;
  logic              frame_err;
  logic [31:0]       shadow_word;
  logic [7:0]        shadow_dp;

  logic [7:0]        sel_n;
  logic              legal;
  logic [2:0]        dig_idx;
  logic              same_sample;
  logic              an_changed;
  logic              capture;
  logic [3:0]        dec_nib;
  logic              dec_bad;
  logic [31:0]       cap_word;
  logic [7:0]        cap_dp;
  logic [7:0]        cap_seen;

  // Returns {bad, nibble}; unknown patterns decode to nibble 0 with bad set.
  function automatic logic [4:0] seg_decode(input logic [6:0] p);
    case (p)
      7'h3F: seg_decode = 5'h00;
      7'h06: seg_decode = 5'h01;
      7'h5B: seg_decode = 5'h02;
      7'h4F: seg_decode = 5'h03;
      7'h66: seg_decode = 5'h04;
      7'h6D: seg_decode = 5'h05;
      7'h7D: seg_decode = 5'h06;
      7'h07: seg_decode = 5'h07;
      7'h7F: seg_decode = 5'h08;
      7'h6F: seg_decode = 5'h09;
      7'h77: seg_decode = 5'h0A;
      7'h7C: seg_decode = 5'h0B;
      7'h39: seg_decode = 5'h0C;
      7'h5E: seg_decode = 5'h0D;
      7'h79: seg_decode = 5'h0E;
      7'h71: seg_decode = 5'h0F;
      default: seg_decode = 5'h10;
    endcase
  endfunction

  // A legal select has exactly one low bit: sel_n is a nonzero power of two.
  assign sel_n       = ~s_an;
  assign legal       = (sel_n != 8'd0) && ((sel_n & (sel_n - 8'd1)) == 8'd0);
  assign same_sample = (s_an == p_an) && (s_cn == p_cn);
  assign an_changed  = (s_an != p_an);
  assign {dec_bad, dec_nib} = seg_decode(~s_cn[6:0]);

  always_comb begin
    dig_idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (sel_n[i]) dig_idx = 3'(i);
    end
  end

  // Capture when the STABLE_CYCLES-th identical sample arrives; with a
  // threshold of one the very first legal sample already qualifies.
  always_comb begin
    capture = 1'b0;
    case (state)
      ST_WAIT:   capture = legal && (STABLE_CYCLES == 1);
      ST_SETTLE: capture = same_sample && (stab_cnt == SC_W'(STABLE_CYCLES - 1));
      ST_HOLD:   capture = an_changed && legal && (STABLE_CYCLES == 1);
      default:   capture = 1'b0;
    endcase
  end

  // Shadow contents as they will be after this capture; used both to update
  // the shadow and to publish a frame completed by this very digit.
  always_comb begin
    cap_word                     = shadow_word;
    cap_word[{dig_idx, 2'b00} +: 4] = dec_nib;
    cap_dp                       = shadow_dp;
    cap_dp[dig_idx]              = ~s_cn[7];
    cap_seen                     = seen | (8'd1 << dig_idx);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_WAIT;
      stab_cnt     <= '0;
      tmo_cnt      <= '0;
      s_an         <= 8'hFF;
      s_cn         <= 8'hFF;
      p_an         <= 8'hFF;
      p_cn         <= 8'hFF;
      seen         <= 8'd0;
      frame_err    <= 1'b0;
      shadow_word  <= 32'd0;
      shadow_dp    <= 8'd0;
      word         <= 32'd0;
      word_valid   <= 1'b0;
      word_changed <= 1'b0;
      dp_mask      <= 8'd0;
      seg_err      <= 1'b0;
      stale        <= 1'b0;
      frame_count  <= '0;
    end else begin
      s_an         <= anodes;
      s_cn         <= cnodes;
      p_an         <= s_an;
      p_cn         <= s_cn;
      word_valid   <= 1'b0;
      word_changed <= 1'b0;

      case (state)
        ST_WAIT: begin
          if (legal) begin
            state    <= capture ? ST_HOLD : ST_SETTLE;
            stab_cnt <= SC_W'(1);
          end
        end
        ST_SETTLE: begin
          if (!same_sample) begin
            if (legal) stab_cnt <= SC_W'(1);
            else       state    <= ST_WAIT;
          end else if (capture) begin
            state <= ST_HOLD;
          end else begin
            stab_cnt <= stab_cnt + SC_W'(1);
          end
        end
        ST_HOLD: begin
          // Segment changes under an unchanged select are ignored here so a
          // single activation is captured only once.
          if (an_changed) begin
            if (legal) begin
              state    <= capture ? ST_HOLD : ST_SETTLE;
              stab_cnt <= SC_W'(1);
            end else begin
              state <= ST_WAIT;
            end
          end
        end
        default: state <= ST_WAIT;
      endcase

      if (capture) begin
        shadow_word <= cap_word;
        shadow_dp   <= cap_dp;
        tmo_cnt     <= '0;
        stale       <= 1'b0;
        if (cap_seen == 8'hFF) begin
          word         <= cap_word;
          dp_mask      <= cap_dp;
          seg_err      <= frame_err | dec_bad;
          word_valid   <= 1'b1;
          word_changed <= (cap_word != word);
          frame_count  <= frame_count + FRAME_CNT_W'(1);
          seen         <= 8'd0;
          frame_err    <= 1'b0;
        end else begin
          seen      <= cap_seen;
          frame_err <= frame_err | dec_bad;
        end
      end else if (tmo_cnt != TO_W'(TIMEOUT_CYCLES)) begin
        tmo_cnt <= tmo_cnt + TO_W'(1);
        if (tmo_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
          // Scanning stopped: drop the partial frame, keep the published word.
          stale     <= 1'b1;
          seen      <= 8'd0;
          frame_err <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// tb/tb_seg7_scan_decoder.sv - scoreboard bench for seg7_scan_decoder
module tb_seg7_scan_decoder;

  localparam int STABLE = 4;
  localparam int TMO    = 64;

  logic        clk;
  logic        rst;
  logic [7:0]  anodes;
  logic [7:0]  cnodes;
  logic [31:0] word;
  logic        word_valid;
  logic        word_changed;
  logic [7:0]  dp_mask;
  logic        seg_err;
  logic        stale;
  logic [15:0] frame_count;

  seg7_scan_decoder #(
    .STABLE_CYCLES (STABLE),
    .TIMEOUT_CYCLES(TMO),
    .FRAME_CNT_W   (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .anodes      (anodes),
    .cnodes      (cnodes),
    .word        (word),
    .word_valid  (word_valid),
    .word_changed(word_changed),
    .dp_mask     (dp_mask),
    .seg_err     (seg_err),
    .stale       (stale),
    .frame_count (frame_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] word;
    logic [7:0]  dp;
    logic        err;
    logic        chg;
    logic [15:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  logic [6:0] font [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Reference model: digits captured so far in the current frame.
  logic [3:0]  m_nib [8];
  logic [7:0]  m_dp;
  logic [7:0]  m_seen;
  logic        m_err;
  logic [31:0] m_last;
  logic [15:0] m_count;
  int          since_cap;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] seg(input logic [3:0] n, input logic dp);
    return ~{dp, font[n]};
  endfunction

  task automatic model_reset();
    m_seen  = 8'd0;
    m_err   = 1'b0;
    m_dp    = 8'd0;
    m_last  = 32'd0;
    m_count = 16'd0;
    for (int i = 0; i < 8; i++) m_nib[i] = 4'd0;
  endtask

  task automatic model_capture(input int d, input logic [7:0] cn);
    logic [3:0]  nib;
    logic        found;
    logic [31:0] w;
    exp_t        e;
    found = 1'b0;
    nib   = 4'd0;
    for (int k = 0; k < 16; k++) begin
      if (font[k] == ~cn[6:0]) begin
        found = 1'b1;
        nib   = 4'(k);
      end
    end
    if (!found) m_err = 1'b1;
    m_nib[d]  = nib;
    m_dp[d]   = ~cn[7];
    m_seen[d] = 1'b1;
    if (m_seen == 8'hFF) begin
      w = 32'd0;
      for (int i = 0; i < 8; i++) w = w + (32'(m_nib[i]) << (4 * i));
      m_count = m_count + 16'd1;
      e.word = w;
      e.dp   = m_dp;
      e.err  = m_err;
      e.chg  = (w != m_last);
      e.cnt  = m_count;
      sb.push_back(e);
      m_last = w;
      m_seen = 8'd0;
      m_err  = 1'b0;
    end
  endtask

  // One activation: pins held for h cycles. A single-low select held for at
  // least STABLE cycles yields exactly one captured digit.
  task automatic act(input logic [7:0] an, input logic [7:0] cn, input int h);
    int d;
    anodes = an;
    cnodes = cn;
    d = 0;
    if ($countones(~an) == 1 && h >= STABLE) begin
      for (int i = 0; i < 8; i++) if (!an[i]) d = i;
      model_capture(d, cn);
      since_cap = 0;
    end else begin
      since_cap += h;
    end
    repeat (h) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic scan_word(input logic [31:0] w, input logic [7:0] dpm, input int h);
    for (int i = 0; i < 8; i++) act(~(8'd1 << i), seg(w[4*i +: 4], dpm[i]), h);
  endtask

  // Monitor: every word_valid pulse must match the oldest expected frame.
  always @(negedge clk) begin
    if (!rst && word_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_word_valid", {32'd0, word}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("word",         word,         e.word);
        chk("dp_mask",      dp_mask,      e.dp);
        chk("seg_err",      seg_err,      e.err);
        chk("word_changed", word_changed, e.chg);
        chk("frame_count",  frame_count,  e.cnt);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] prev_an;
    logic [7:0] an;
    logic [7:0] cn;
    logic [31:0] w;
    int r, a, b, h;

    model_reset();
    since_cap = 0;
    rst    = 1'b1;
    anodes = 8'hFF;
    cnodes = 8'hFF;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_word",        word,         0);
    chk("rst_word_valid",  word_valid,   0);
    chk("rst_dp_mask",     dp_mask,      0);
    chk("rst_seg_err",     seg_err,      0);
    chk("rst_stale",       stale,        0);
    chk("rst_frame_count", frame_count,  0);
    rst = 1'b0;

    // Plain frame, then an identical one.
    scan_word(32'h12345678, 8'h00, 8);
    scan_word(32'h12345678, 8'h00, 8);

    // Digit 3 too short: the frame completes only after it is rescanned.
    for (int i = 0; i < 8; i++) act(~(8'd1 << i), seg(32'h12345678 >> (4*i), 1'b0), (i == 3) ? 3 : 8);
    act(~8'h08, seg(4'h5, 1'b0), 8);

    // Undecodable segment pattern on digit 5, then a clean frame.
    for (int i = 0; i < 8; i++) begin
      w = 32'hDEADBEEF;
      act(~(8'd1 << i), (i == 5) ? (8'hFF ^ 8'h12) : seg(w[4*i +: 4], 1'b0), 8);
    end
    scan_word(32'hCAFEF00D, 8'h00, 8);

    // Illegal selects mid-frame and decimal points on digits 0 and 7.
    for (int i = 0; i < 8; i++) begin
      w = 32'h0F1E2D3C;
      act(~(8'd1 << i), seg(w[4*i +: 4], (i == 0) || (i == 7)), 8);
      if (i == 3) begin
        act(8'hFC, seg(4'h8, 1'b1), 20);
        act(8'hFF, seg(4'h8, 1'b1), 20);
      end
    end

    // Timeout after a partial frame; the partial digits must be dropped.
    w = 32'h89ABCDEF;
    for (int i = 0; i < 4; i++) act(~(8'd1 << i), seg(w[4*i +: 4], 1'b0), 8);
    act(8'hFF, 8'hFF, 40);
    chk("stale_before_timeout", stale, 0);
    act(8'hFF, 8'hFF, 40);
    chk("stale_after_timeout", stale, 1);
    chk("word_held_when_stale", word, m_last);
    m_seen = 8'd0;
    m_err  = 1'b0;
    w = 32'h76543210;
    act(~8'h10, seg(w[19:16], 1'b0), 8);
    chk("stale_cleared_by_capture", stale, 0);
    for (int i = 5; i < 8; i++) act(~(8'd1 << i), seg(w[4*i +: 4], 1'b0), 8);
    for (int i = 0; i < 4; i++) act(~(8'd1 << i), seg(w[4*i +: 4], 1'b0), 8);

    // Reset after five digits.
    for (int i = 0; i < 5; i++) act(~(8'd1 << i), seg(4'(i + 9), 1'b1), 8);
    repeat (3) @(posedge clk);
    anodes = 8'hFF;
    cnodes = 8'hFF;
    rst    = 1'b1;
    @(posedge clk);
    #1;
    chk("rst2_word",         word,         0);
    chk("rst2_dp_mask",      dp_mask,      0);
    chk("rst2_word_valid",   word_valid,   0);
    chk("rst2_word_changed", word_changed, 0);
    chk("rst2_seg_err",      seg_err,      0);
    chk("rst2_frame_count",  frame_count,  0);
    rst = 1'b0;
    model_reset();
    since_cap = 0;
    scan_word($urandom, 8'($urandom), 8);

    // Randomized scanning with glitches, illegal selects and repeats.
    prev_an = 8'hFF;
    for (int n = 0; n < 220; n++) begin
      r = $urandom_range(0, 9);
      cn = (r == 0) ? 8'($urandom) : seg(4'($urandom), 1'($urandom));
      r = (since_cap > 30) ? 5 : $urandom_range(0, 5);
      if (r == 0) begin
        a = $urandom_range(0, 7);
        b = (a + $urandom_range(1, 7)) % 8;
        an = ($urandom_range(0, 1) == 0) ? 8'hFF : ~((8'd1 << a) | (8'd1 << b));
        h = $urandom_range(1, 3);
      end else begin
        an = ~(8'd1 << $urandom_range(0, 7));
        h = (r == 1) ? $urandom_range(1, STABLE - 1) : $urandom_range(STABLE, STABLE + 4);
        if (an == prev_an) act(8'hFF, 8'hFF, 1);
      end
      act(an, cn, h);
      prev_an = an;
    end
    act(8'hFF, 8'hFF, 10);
    chk("scoreboard_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
